im_fetch_ctrl: RTL and testbench

Multi-cycle instruction fetch sequencer placed between the PC logic and the byte-addressed, big-endian instruction memory (IM). It owns the PC and drives the IM address. It waits a configurable number of cycles for IM data, then latches the 32-bit word into the instruction register (IR). The IR is handed to decode over a valid/ready handshake, and the block also handles branch/jump redirects, halt and address faults.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_wait_counter.sv | 33 +++
 rtl/im_fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_im_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-sequencer definitions: state encoding, instruction size
// and the fetch address legality check.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WAIT  = 3'd1,
        S_LATCH = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam int          CNT_W       = 4;

    // A fetch is illegal when misaligned or when the word would run past the IM.
    function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                            input logic [31:0] last_ok);
        return (addr[1:0] != 2'b00) || (addr > last_ok);
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Wait-state counter for the IM access: clear, count up, and flag the
// terminal count supplied by the fetch FSM.
module fetch_wait_counter
    import cpu_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_tc_value,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Count register: clear has priority over increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_clear) begin
            r_count <= {W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == i_tc_value);

endmodule

// File: rtl/im_fetch_ctrl.sv
// Multi-cycle instruction fetch sequencer: owns the PC, drives the IM address,
// latches the fetched word into IR and hands it to decode over valid/ready.
module im_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IM_BYTES    = 101,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ir_ready,
    input  logic [31:0] im_data,
    output logic [31:0] im_addr,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic        fault
);

    localparam logic [31:0]      LAST_FETCH = 32'(IM_BYTES - 4);
    localparam logic [CNT_W-1:0] WAIT_TC    = CNT_W'(WAIT_CYCLES - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc, r_im_addr, r_ir;
    logic        r_ir_valid, r_fault;

    logic [31:0] w_pc_nxt, w_im_addr_nxt, w_ir_nxt;
    logic        w_ir_valid_nxt, w_fault_nxt;
    logic        w_cnt_clear, w_cnt_en, w_cnt_tc;
    logic        w_pc_bad;
    logic [31:0] w_pc_seq;

    fetch_wait_counter #(
        .W          (CNT_W)
    ) u_wait_cnt (
        .i_clk      (CLK),
        .i_rst_n    (Reset),
        .i_clear    (w_cnt_clear),
        .i_en       (w_cnt_en),
        .i_tc_value (WAIT_TC),
        .o_tc       (w_cnt_tc)
    );

    assign w_pc_bad = fetch_addr_bad(r_pc, LAST_FETCH);
    assign w_pc_seq = r_pc + INSTR_BYTES;

    // State and datapath registers; every output is driven from here.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state    <= S_ISSUE;
            r_pc       <= RESET_PC;
            r_im_addr  <= RESET_PC;
            r_ir       <= 32'h0000_0000;
            r_ir_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_im_addr  <= w_im_addr_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    // Next-state and next-datapath decode; redirect outranks every other event.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_im_addr_nxt  = r_im_addr;
        w_ir_nxt       = r_ir;
        w_ir_valid_nxt = r_ir_valid;
        w_fault_nxt    = r_fault;
        w_cnt_clear    = 1'b0;
        w_cnt_en       = 1'b0;

        case (r_state)
            S_ISSUE: begin
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = S_ISSUE;
                end else if (w_pc_bad) begin
                    w_fault_nxt    = 1'b1;
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = S_FAULT;
                end else begin
                    w_im_addr_nxt  = r_pc;
                    w_cnt_clear    = 1'b1;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = S_ISSUE;
                end else if (w_cnt_tc) begin
                    w_cnt_en       = 1'b1;
                    w_state_nxt    = S_LATCH;
                end else begin
                    w_cnt_en       = 1'b1;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_LATCH: begin
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = S_ISSUE;
                end else begin
                    w_ir_nxt       = im_data;
                    w_ir_valid_nxt = 1'b1;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                // A redirect alongside ir_ready still retires the IR; only the PC differs.
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = S_ISSUE;
                end else if (r_ir_valid && ir_ready) begin
                    w_pc_nxt       = w_pc_seq;
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = halt ? S_HALT : S_ISSUE;
                end else begin
                    w_state_nxt    = S_HOLD;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    w_pc_nxt       = redirect_pc;
                    w_state_nxt    = S_HALT;
                end else if (!halt) begin
                    w_state_nxt    = S_ISSUE;
                end else begin
                    w_state_nxt    = S_HALT;
                end
            end
            S_FAULT: begin
                w_fault_nxt    = 1'b1;
                w_ir_valid_nxt = 1'b0;
                w_state_nxt    = S_FAULT;
            end
            default: begin
                w_fault_nxt    = 1'b1;
                w_ir_valid_nxt = 1'b0;
                w_state_nxt    = S_FAULT;
            end
        endcase
    end

    assign im_addr  = r_im_addr;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc       = r_pc;
    assign fault    = r_fault;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl: big-endian byte IM model, one task per scenario.
module tb_im_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ir_ready = 1'b0;
    logic [31:0] im_data;
    logic [31:0] im_addr, ir, pc;
    logic        ir_valid, fault;

    logic [7:0]  mem [0:127];
    int          n_vec = 0;
    int          n_err = 0;

    im_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .IM_BYTES    (101),
        .WAIT_CYCLES (1)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_ready       (ir_ready),
        .im_data        (im_data),
        .im_addr        (im_addr),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .pc             (pc),
        .fault          (fault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a <= 32'd124)
            return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
        else
            return 32'h0;
    endfunction

    assign im_data = rd_word(im_addr);

    task automatic set_word(input int a, input logic [31:0] w);
        mem[a]   = w[31:24];
        mem[a+1] = w[23:16];
        mem[a+2] = w[15:8];
        mem[a+3] = w[7:0];
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0; ir_ready = 1'b0;
        tick(); tick();
        Reset = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (ir_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        n_vec++;
        if (ir_valid !== 1'b1) begin
            $display("FAIL wait_valid: ir_valid=%b required 1 within %0d cycles", ir_valid, budget);
            n_err++;
        end
    endtask

    task automatic accept_one();
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; tick(); tick();
        n_vec++; if (pc !== 32'h0 || im_addr !== 32'h0) begin
            $display("FAIL reset_pc: pc=%h im_addr=%h required 0/0", pc, im_addr); n_err++; end
        n_vec++; if (ir !== 32'h0 || ir_valid !== 1'b0 || fault !== 1'b0) begin
            $display("FAIL reset_ir: ir=%h ir_valid=%b fault=%b required 0/0/0", ir, ir_valid, fault); n_err++; end
        Reset = 1'b1; ir_ready = 1'b1;
        tick();
        n_vec++; if (ir_valid !== 1'b0 || im_addr !== 32'h0) begin
            $display("FAIL first_edge: ir_valid=%b im_addr=%h required 0/0", ir_valid, im_addr); n_err++; end
        tick();
        n_vec++; if (ir_valid !== 1'b0) begin
            $display("FAIL second_edge: ir_valid=%b required 0", ir_valid); n_err++; end
        tick();
        n_vec++; if (ir_valid !== 1'b1 || ir !== 32'h8C01_0004 || pc !== 32'h0) begin
            $display("FAIL word0: ir_valid=%b ir=%h pc=%h required 1/8c010004/0", ir_valid, ir, pc); n_err++; end
        tick();
        n_vec++; if (ir_valid !== 1'b0 || pc !== 32'h4) begin
            $display("FAIL accept0: ir_valid=%b pc=%h required 0/4", ir_valid, pc); n_err++; end
        tick(); tick(); tick();
        n_vec++; if (ir_valid !== 1'b1 || ir !== 32'h0002_1820 || pc !== 32'h4) begin
            $display("FAIL word1: ir_valid=%b ir=%h pc=%h required 1/00021820/4", ir_valid, ir, pc); n_err++; end
        ir_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (ir_valid !== 1'b1 || ir !== 32'h0002_1820 || pc !== 32'h4 || im_addr !== 32'h4) begin
                $display("FAIL stall%0d: v=%b ir=%h pc=%h im_addr=%h required 1/00021820/4/4",
                         i, ir_valid, ir, pc, im_addr); n_err++; end
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        n_vec++; if (pc !== 32'h8 || ir_valid !== 1'b0) begin
            $display("FAIL release: pc=%h ir_valid=%b required 8/0", pc, ir_valid); n_err++; end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (pc !== 32'h10 || ir_valid !== 1'b0) begin
            $display("FAIL rdw_pc: pc=%h ir_valid=%b required 10/0", pc, ir_valid); n_err++; end
        tick();
        n_vec++; if (im_addr !== 32'h10 || ir_valid !== 1'b0) begin
            $display("FAIL rdw_addr: im_addr=%h ir_valid=%b required 10/0", im_addr, ir_valid); n_err++; end
        tick(); tick();
        n_vec++; if (ir_valid !== 1'b1 || ir !== 32'h1122_3344 || pc !== 32'h10) begin
            $display("FAIL rdw_word: v=%b ir=%h pc=%h required 1/11223344/10", ir_valid, ir, pc); n_err++; end
    endtask

    task automatic test_redirect_handshake();
        do_reset();
        wait_valid(10); accept_one();
        wait_valid(10); accept_one();
        wait_valid(10);
        n_vec++; if (ir !== 32'h3C0A_1234 || pc !== 32'h8) begin
            $display("FAIL rdh_pre: ir=%h pc=%h required 3c0a1234/8", ir, pc); n_err++; end
        ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
        tick();
        ir_ready = 1'b0; redirect_valid = 1'b0;
        n_vec++; if (pc !== 32'h20 || ir_valid !== 1'b0) begin
            $display("FAIL rdh_pc: pc=%h ir_valid=%b required 20/0", pc, ir_valid); n_err++; end
        wait_valid(10);
        n_vec++; if (ir !== 32'hDEAD_BEEF || pc !== 32'h20 || im_addr !== 32'h20) begin
            $display("FAIL rdh_word: ir=%h pc=%h im_addr=%h required deadbeef/20/20", ir, pc, im_addr); n_err++; end
    endtask

    task automatic test_halt();
        do_reset();
        tick();
        halt = 1'b1;
        wait_valid(10);
        n_vec++; if (ir !== 32'h8C01_0004) begin
            $display("FAIL halt_wait: ir=%h required 8c010004", ir); n_err++; end
        accept_one();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (im_addr !== 32'h0 || pc !== 32'h4 || ir_valid !== 1'b0 || ir !== 32'h8C01_0004) begin
                $display("FAIL halted%0d: im_addr=%h pc=%h v=%b ir=%h required 0/4/0/8c010004",
                         i, im_addr, pc, ir_valid, ir); n_err++; end
        end
        halt = 1'b0;
        tick(); tick();
        n_vec++; if (im_addr !== 32'h4) begin
            $display("FAIL resume_addr: im_addr=%h required 4", im_addr); n_err++; end
        wait_valid(10);
        n_vec++; if (ir !== 32'h0002_1820 || pc !== 32'h4) begin
            $display("FAIL resume_word: ir=%h pc=%h required 00021820/4", ir, pc); n_err++; end
    endtask

    task automatic test_fault(input logic [31:0] target, input logic exp_fault, input logic [31:0] exp_ir);
        do_reset();
        wait_valid(10);
        redirect_valid = 1'b1; redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_vec++; if (fault !== exp_fault || ir_valid !== 1'b0) begin
            $display("FAIL fault_%0d: fault=%b ir_valid=%b required %b/0", target, fault, ir_valid, exp_fault); n_err++; end
        if (exp_fault) begin
            n_vec++; if (im_addr !== 32'h0) begin
                $display("FAIL fault_addr_%0d: im_addr=%h required 0", target, im_addr); n_err++; end
            redirect_valid = 1'b1; redirect_pc = 32'h0; ir_ready = 1'b1;
            tick(); tick(); tick();
            redirect_valid = 1'b0; ir_ready = 1'b0;
            n_vec++; if (fault !== 1'b1 || pc !== target || ir_valid !== 1'b0) begin
                $display("FAIL fault_sticky_%0d: fault=%b pc=%h v=%b required 1/%h/0",
                         target, fault, pc, ir_valid, target); n_err++; end
            Reset = 1'b0; tick(); Reset = 1'b1;
            n_vec++; if (fault !== 1'b0 || pc !== 32'h0) begin
                $display("FAIL fault_clear_%0d: fault=%b pc=%h required 0/0", target, fault, pc); n_err++; end
        end else begin
            wait_valid(10);
            n_vec++; if (ir !== exp_ir || pc !== target || fault !== 1'b0) begin
                $display("FAIL edge_fetch_%0d: ir=%h pc=%h fault=%b required %h/%h/0",
                         target, ir, pc, fault, exp_ir, target); n_err++; end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        set_word(0,  32'h8C01_0004);
        set_word(4,  32'h0002_1820);
        set_word(8,  32'h3C0A_1234);
        set_word(12, 32'hAABB_CCDD);
        set_word(16, 32'h1122_3344);
        set_word(32, 32'hDEAD_BEEF);
        set_word(96, 32'h0F0E_0D0C);

        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_handshake();
        test_halt();
        test_fault(32'h0000_0002, 1'b1, 32'h0);
        test_fault(32'h0000_0064, 1'b1, 32'h0);
        test_fault(32'h0000_0060, 1'b0, 32'h0F0E_0D0C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
